freq_div_gen: RTL

//   Programmable pulse generator: produces square-ish wave psi, high phase = div cycles, low phase = LOW_LEN cycles.

---
 rtl/freq_div_gen_pkg.sv | 18 +
 rtl/freqdiv_phase_cnt.sv | 40 ++++
 rtl/freq_div_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/freq_div_gen_pkg.sv
// -----------------------------------------------------------------------------
// freq_div_gen_pkg
//   Shared definitions for the programmable pulse generator: FSM state
//   encodings and the divisor value loaded at reset.
//   The reset divisor matches the frequency regulator's reset value. This keeps
//   the closed loop consistent straight out of reset.
// -----------------------------------------------------------------------------
package freq_div_gen_pkg;

  typedef enum logic [1:0] {
    FD_IDLE = 2'd0,
    FD_HIGH = 2'd1,
    FD_LOW  = 2'd2
  } fd_state_e;

  localparam logic [7:0] FD_RESET_DIV = 8'h7F;

endpackage : freq_div_gen_pkg

// File: rtl/freqdiv_phase_cnt.sv
// -----------------------------------------------------------------------------
// freqdiv_phase_cnt
//   WIDTH-bit loadable down-counter that times the high and low phases.
//   The count stops at zero and never wraps.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (count -> 0)
//   load      in   load load_val this cycle (takes priority over dec)
//   load_val  in   value to load
//   dec       in   decrement by one (ignored when already zero)
//   cnt       out  current count
//   zero      out  cnt == 0
// -----------------------------------------------------------------------------
module freqdiv_phase_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  // NOTE: clocked state is always assigned with <= so every register samples
  // pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

endmodule : freqdiv_phase_cnt

// File: rtl/freq_div_gen.sv
// -----------------------------------------------------------------------------
// freq_div_gen
//   Programmable pulse generator. Produces psi as a high phase of eff(div)
//   cycles followed by a low phase of LOW_LEN cycles. div is sampled only at
//   period boundaries, so divisor changes never produce a glitch.
//   If en drops mid-period, the current period still completes before the
//   block returns to idle.
//   Optional build macro: FREQDIV_MINCLAMP_EN. When defined, the high phase is
//   clamped to at least MIN_DIV cycles. When undefined, only div==0 is
//   promoted to 1.
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   en           in   run request (level)
//   div          in   requested high-phase length
//   psi          out  generated waveform (registered)
//   period_done  out  one-cycle pulse on the last cycle of each low phase
//   active       out  high while the FSM is not idle
//   div_shadow   out  divisor in use for the current period
// -----------------------------------------------------------------------------
module freq_div_gen
  import freq_div_gen_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LOW_LEN = 16,
  parameter int MIN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             psi,
  output logic             period_done,
  output logic             active,
  output logic [WIDTH-1:0] div_shadow
);

  fd_state_e        state;
  logic [WIDTH-1:0] eff_div;
  logic [WIDTH-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_dec;

  // Effective divisor. A zero-length high phase is never allowed.
`ifdef FREQDIV_MINCLAMP_EN
  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    eff_div = div;
    if (div < MIN_DIV_W) eff_div = MIN_DIV_W;
  end
`else
  logic [31:0] unused_min_div;
  assign unused_min_div = MIN_DIV;

  always_comb begin
    eff_div = div;
    if (div == '0) eff_div = WIDTH'(1);
  end
`endif

  // Counter control. A load starts a new phase: the high phase is loaded from
  // idle or at the end of a low phase, and the low phase is loaded at the end
  // of a high phase.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = eff_div - WIDTH'(1);
    cnt_dec      = 1'b0;
    case (state)
      FD_IDLE: cnt_load = en;
      FD_HIGH: begin
        cnt_load     = cnt_zero;
        cnt_load_val = WIDTH'(LOW_LEN - 1);
        cnt_dec      = 1'b1;
      end
      FD_LOW: begin
        cnt_load = cnt_zero && en;
        cnt_dec  = 1'b1;
      end
      default: ;
    endcase
  end

  freqdiv_phase_cnt #(
    .WIDTH (WIDTH)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // FSM with registered outputs. Every output is assigned on the edge that
  // enters the cycle it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FD_IDLE;
      psi         <= 1'b0;
      period_done <= 1'b0;
      active      <= 1'b0;
      div_shadow  <= WIDTH'(FD_RESET_DIV);
    end else begin
      period_done <= 1'b0;
      case (state)
        FD_IDLE: begin
          if (en) begin
            state      <= FD_HIGH;
            psi        <= 1'b1;
            active     <= 1'b1;
            div_shadow <= eff_div;
          end else begin
            psi    <= 1'b0;
            active <= 1'b0;
          end
        end
        FD_HIGH: begin
          if (cnt_zero) begin
            state       <= FD_LOW;
            psi         <= 1'b0;
            // A single-cycle low phase is also its own last cycle.
            period_done <= (LOW_LEN == 1);
          end
        end
        FD_LOW: begin
          // The pulse is registered, so it is raised one edge ahead of the
          // last low cycle (count about to reach zero).
          if (!cnt_zero && cnt == WIDTH'(1)) period_done <= 1'b1;
          if (cnt_zero) begin
            if (en) begin
              state      <= FD_HIGH;
              psi        <= 1'b1;
              div_shadow <= eff_div;
            end else begin
              state  <= FD_IDLE;
              active <= 1'b0;
            end
          end
        end
        default: begin
          // Unreachable encoding: recover to idle.
          state  <= FD_IDLE;
          psi    <= 1'b0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule : freq_div_gen
